uart16550_axil_rxctl: RTL and testbench

Receive-path controller for the 16-entry `uart1655_axil_fifo`. It owns the FIFO's `write`, `read`, `regmode` and `clear_flag` inputs. It decodes FCR writes (FIFO enable, RX/TX reset, trigger level) and drains the RX FIFO on reset requests. It also arbitrates FIFO reads between the host RBR path and the drain sequencer, and produces the RX-data-available and character-timeout interrupt sources used by the IIR logic.

---
 rtl/uart16550_axil_rxctl.sv | 213 +++++++++++++++++++++
 tb/tb_uart16550_axil_rxctl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart16550_axil_rxctl.sv
// ---------------------------------------------------------------------------
// uart16550_axil_rxctl
//
// Receive-path controller for the 16-entry UART FIFO. It decodes FCR writes
// (FIFO enable, RX/TX reset, trigger level) and owns the FIFO write/read/
// regmode/clear_flag controls. It arbitrates FIFO reads between the host RBR
// path and a drain sequencer that empties the RX FIFO on reset requests. It
// also produces the RX-data-available and character-timeout interrupt
// sources.
//
// Optional feature macro: UART16550_RX_TIMEOUT_EN
//   defined   : character-timeout counter and rx_timeout are built.
//   undefined : no counter, rx_timeout tied 0, char_tick unused.
//
// Strobe semantics: every input strobe (fcr_we, host_rd, lsr_rd, rx_push,
// char_tick) is a single-cycle pulse sampled at the rising edge of clk. There
// is no back-pressure. fifo_read/fifo_write/fifo_clear_flag are combinational
// single-cycle commands that the FIFO acts on at the same edge. fifo_read is
// only ever issued when the FIFO reports non-empty.
//
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   fcr_wdata/fcr_we  FCR write: [0] FIFO en, [1] RX rst, [2] TX rst, [7:6] trig
//   host_rd           host RBR read strobe
//   lsr_rd            host LSR read strobe (forwarded as overrun clear)
//   rx_push           receiver character-valid strobe
//   char_tick         one pulse per character time
//   fifo_elems        FIFO occupancy 0..16
//   fifo_empty        FIFO empty flag
//   fifo_write        FIFO write command
//   fifo_read         FIFO read command
//   fifo_regmode      1 = 16450 single-register mode
//   fifo_clear_flag   FIFO overrun clear
//   fifo_en           current FCR[0]
//   tx_flush          one-cycle TX FIFO reset request
//   rx_busy           drain in progress (also exposes the FSM state)
//   rx_trig           RX-data-available interrupt source
//   rx_timeout        character-timeout interrupt source
// ---------------------------------------------------------------------------
module uart16550_axil_rxctl #(
    parameter int TIMEOUT_CHARS = 4,
    parameter int TCNT_W        = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] fcr_wdata,
    input  logic       fcr_we,
    input  logic       host_rd,
    input  logic       lsr_rd,
    input  logic       rx_push,
    input  logic       char_tick,
    input  logic [4:0] fifo_elems,
    input  logic       fifo_empty,
    output logic       fifo_write,
    output logic       fifo_read,
    output logic       fifo_regmode,
    output logic       fifo_clear_flag,
    output logic       fifo_en,
    output logic       tx_flush,
    output logic       rx_busy,
    output logic       rx_trig,
    output logic       rx_timeout
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] trig_sel;
    logic [4:0] trig_level;
    logic       en_toggle;
    logic       drain_req;

    // Changing the FIFO enable always flushes the RX FIFO, as does RX reset.
    assign en_toggle = fcr_we & (fcr_wdata[0] != fifo_en);
    assign drain_req = (fcr_we & fcr_wdata[1]) | en_toggle;

    assign fifo_regmode    = ~fifo_en;
    assign fifo_clear_flag = reset_n & lsr_rd;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state. Further drain requests while draining are absorbed.
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (drain_req)  state_nxt = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs. FIFO commands are held off while reset is asserted.
    // -----------------------------------------------------------------------
    always_comb begin
        fifo_read  = 1'b0;
        fifo_write = 1'b0;
        rx_busy    = (state == ST_DRAIN);
        if (reset_n) begin
            case (state)
                ST_IDLE: begin
                    fifo_read  = host_rd & ~fifo_empty;
                    fifo_write = rx_push;
                end
                ST_DRAIN: begin
                    // Host reads ignored, received characters discarded.
                    fifo_read  = ~fifo_empty;
                end
                default: begin
                    fifo_read  = 1'b0;
                    fifo_write = 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FCR fields and TX flush pulse
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fifo_en  <= 1'b0;
            trig_sel <= 2'b00;
            tx_flush <= 1'b0;
        end else begin
            tx_flush <= fcr_we & (fcr_wdata[2] | (fcr_wdata[0] != fifo_en));
            if (fcr_we) begin
                fifo_en  <= fcr_wdata[0];
                trig_sel <= fcr_wdata[7:6];
            end
        end
    end

    always_comb begin
        trig_level = 5'd1;
        case (trig_sel)
            2'b00: trig_level = 5'd1;
            2'b01: trig_level = 5'd4;
            2'b10: trig_level = 5'd8;
            2'b11: trig_level = 5'd14;
            default: trig_level = 5'd1;
        endcase
    end

    // -----------------------------------------------------------------------
    // RX-data-available source. Suppressed while the FIFO is being drained.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_trig <= 1'b0;
        end else if (state == ST_DRAIN) begin
            rx_trig <= 1'b0;
        end else if (fifo_en) begin
            rx_trig <= (fifo_elems >= trig_level);
        end else begin
            rx_trig <= ~fifo_empty;
        end
    end

    // -----------------------------------------------------------------------
    // Character timeout
    // -----------------------------------------------------------------------
`ifdef UART16550_RX_TIMEOUT_EN
    localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT_CHARS);

    logic [TCNT_W-1:0] tcnt;
    logic              tcnt_clr;

    // Any FIFO activity or an empty FIFO restarts the idle-time measurement.
    assign tcnt_clr = rx_push | fifo_read | (state == ST_DRAIN) | fifo_empty;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tcnt       <= '0;
            rx_timeout <= 1'b0;
        end else begin
            if (tcnt_clr) begin
                tcnt <= '0;
            end else if (char_tick && (tcnt != TCNT_MAX)) begin
                tcnt <= tcnt + TCNT_W'(1);
            end
            rx_timeout <= fifo_en & ~fifo_empty & (tcnt == TCNT_MAX);
        end
    end

    logic unused_sig;
    assign unused_sig = &{1'b0, fcr_wdata[5:3]};
`else
    localparam int unused_timeout_chars = TIMEOUT_CHARS;
    localparam int unused_tcnt_w        = TCNT_W;

    assign rx_timeout = 1'b0;

    logic unused_sig;
    assign unused_sig = &{1'b0, char_tick, fcr_wdata[5:3]};
`endif

endmodule

// File: tb/tb_uart16550_axil_rxctl.sv
// ---------------------------------------------------------------------------
// Testbench for uart16550_axil_rxctl. A small behavioural FIFO model sits on
// the controller's FIFO ports; expected read pulses during drains come from a
// scoreboard queue filled when the FCR write is driven.
// ---------------------------------------------------------------------------
module tb_uart16550_axil_rxctl;

`ifdef UART16550_RX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] fcr_wdata = 8'h00;
  logic       fcr_we = 1'b0;
  logic       host_rd = 1'b0;
  logic       lsr_rd = 1'b0;
  logic       rx_push = 1'b0;
  logic       char_tick = 1'b0;
  logic [4:0] fifo_elems;
  logic       fifo_empty;
  logic       fifo_write;
  logic       fifo_read;
  logic       fifo_regmode;
  logic       fifo_clear_flag;
  logic       fifo_en;
  logic       tx_flush;
  logic       rx_busy;
  logic       rx_trig;
  logic       rx_timeout;

  uart16550_axil_rxctl #(
    .TIMEOUT_CHARS(4),
    .TCNT_W(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .fcr_wdata(fcr_wdata),
    .fcr_we(fcr_we),
    .host_rd(host_rd),
    .lsr_rd(lsr_rd),
    .rx_push(rx_push),
    .char_tick(char_tick),
    .fifo_elems(fifo_elems),
    .fifo_empty(fifo_empty),
    .fifo_write(fifo_write),
    .fifo_read(fifo_read),
    .fifo_regmode(fifo_regmode),
    .fifo_clear_flag(fifo_clear_flag),
    .fifo_en(fifo_en),
    .tx_flush(tx_flush),
    .rx_busy(rx_busy),
    .rx_trig(rx_trig),
    .rx_timeout(rx_timeout)
  );

  // -------------------------------------------------------------------------
  // FIFO model (occupancy + overrun flag)
  // -------------------------------------------------------------------------
  logic [4:0] m_elems = 5'd0;
  logic       m_oe = 1'b0;
  int         n_next;
  logic       oe_set;

  assign fifo_elems = m_elems;
  assign fifo_empty = (m_elems == 5'd0);

  always_comb begin
    n_next = int'(m_elems);
    oe_set = 1'b0;
    if (fifo_read && n_next > 0) n_next = n_next - 1;
    if (fifo_write) begin
      if (n_next < (fifo_regmode ? 1 : 16)) n_next = n_next + 1;
      else oe_set = 1'b1;
    end
  end

  always @(posedge clk) begin
    m_elems <= 5'(n_next);
    if (fifo_clear_flag) m_oe <= 1'b0;
    else if (oe_set) m_oe <= 1'b1;
  end

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  logic [0:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_drain(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
  endtask

  // One cycle per expected entry: pushes and host reads are thrown at the DUT
  // throughout and must be ignored. fcr_at selects a cycle for an extra FCR
  // RX reset that must be absorbed.
  task automatic run_drain(input int fcr_at, input int max_cyc);
    int guard;
    logic [0:0] e;
    guard = 0;
    while (exp_q.size() > 0 && guard < max_cyc) begin
      rx_push   = 1'b1;
      host_rd   = 1'($urandom_range(0, 1));
      fcr_we    = (guard == fcr_at);
      fcr_wdata = 8'hC3;
      #1;
      e = exp_q.pop_front();
      chk("drain_read", {31'd0, fifo_read}, {31'd0, e});
      chk("drain_write", {31'd0, fifo_write}, 32'd0);
      chk("drain_busy", {31'd0, rx_busy}, 32'd1);
      chk("drain_clr", {31'd0, fifo_clear_flag}, 32'd0);
      @(negedge clk);
      guard++;
    end
    rx_push = 1'b0;
    host_rd = 1'b0;
    fcr_we  = 1'b0;
    chk("drain_bound", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic fcr_write(input logic [7:0] d);
    fcr_wdata = d;
    fcr_we    = 1'b1;
    @(negedge clk);
    fcr_we    = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    // Reset: FIFO commands gated even with strobes active.
    repeat (2) @(negedge clk);
    host_rd = 1'b1; rx_push = 1'b1; lsr_rd = 1'b1;
    #1;
    chk("rst_read", {31'd0, fifo_read}, 32'd0);
    chk("rst_write", {31'd0, fifo_write}, 32'd0);
    chk("rst_clr", {31'd0, fifo_clear_flag}, 32'd0);
    chk("rst_regmode", {31'd0, fifo_regmode}, 32'd1);
    chk("rst_regs", {26'd0, fifo_en, tx_flush, rx_busy, rx_trig, rx_timeout, 1'b0}, 32'd0);
    host_rd = 1'b0; rx_push = 1'b0; lsr_rd = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // FCR=0x01 on an empty FIFO: one-cycle drain, TX flush on enable toggle.
    fcr_wdata = 8'h01; fcr_we = 1'b1;
    #1;
    chk("t1_regmode_pre", {31'd0, fifo_regmode}, 32'd1);
    @(negedge clk);
    fcr_we = 1'b0;
    #1;
    chk("t1_regmode", {31'd0, fifo_regmode}, 32'd0);
    chk("t1_busy", {31'd0, rx_busy}, 32'd1);
    chk("t1_flush", {31'd0, tx_flush}, 32'd1);
    chk("t1_read_empty", {31'd0, fifo_read}, 32'd0);
    @(negedge clk);
    chk("t1_busy_end", {31'd0, rx_busy}, 32'd0);
    chk("t1_flush_end", {31'd0, tx_flush}, 32'd0);

    // Trigger level 14.
    fcr_write(8'hC1);
    chk("t2_no_drain", {31'd0, rx_busy}, 32'd0);
    for (int i = 0; i < 13; i++) begin
      rx_push = 1'b1;
      #1;
      chk("t2_write", {31'd0, fifo_write}, 32'd1);
      @(negedge clk);
    end
    rx_push = 1'b0;
    @(negedge clk);
    chk("t2_trig13", {31'd0, rx_trig}, 32'd0);
    rx_push = 1'b1;
    @(negedge clk);
    rx_push = 1'b0;
    chk("t2_trig_latency", {31'd0, rx_trig}, 32'd0);
    @(negedge clk);
    chk("t2_trig14", {31'd0, rx_trig}, 32'd1);
    host_rd = 1'b1;
    #1;
    chk("t2_host_read", {31'd0, fifo_read}, 32'd1);
    @(negedge clk);
    host_rd = 1'b0;
    @(negedge clk);
    chk("t2_trig_after_rd", {31'd0, rx_trig}, 32'd0);

    // Drain of 10 entries with pushes discarded.
    host_rd = 1'b1;
    repeat (3) @(negedge clk);
    host_rd = 1'b0;
    chk("t3_elems10", {27'd0, fifo_elems}, 32'd10);
    expect_drain(10);
    fcr_write(8'h03);
    run_drain(-1, 40);
    chk("t3_busy_done", {31'd0, rx_busy}, 32'd0);
    chk("t3_elems0", {27'd0, fifo_elems}, 32'd0);
    chk("t3_trig", {31'd0, rx_trig}, 32'd0);
    rx_push = 1'b1;
    @(negedge clk);
    rx_push = 1'b0;
    host_rd = 1'b1;
    #1;
    chk("t3_host_rd_again", {31'd0, fifo_read}, 32'd1);
    @(negedge clk);
    host_rd = 1'b0;
    chk("t3_elems_after", {27'd0, fifo_elems}, 32'd0);

    // Character timeout.
    fcr_write(8'h01);
    rx_push = 1'b1;
    repeat (2) @(negedge clk);
    rx_push = 1'b0;
    char_tick = 1'b1;
    repeat (4) @(negedge clk);
    char_tick = 1'b0;
    chk("t4_to_early", {31'd0, rx_timeout}, 32'd0);
    @(negedge clk);
    chk("t4_to_set", {31'd0, rx_timeout}, {31'd0, TO_EN});
    rx_push = 1'b1;
    @(negedge clk);
    rx_push = 1'b0;
    @(negedge clk);
    chk("t4_to_clr", {31'd0, rx_timeout}, 32'd0);

    // Host read on an empty FIFO.
    host_rd = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_elems0", {27'd0, fifo_elems}, 32'd0);
    #1;
    chk("t4_rd_empty", {31'd0, fifo_read}, 32'd0);
    @(negedge clk);
    host_rd = 1'b0;

    // Overrun: clear via LSR read; a drain does not clear it.
    rx_push = 1'b1;
    repeat (16) @(negedge clk);
    chk("t5_full", {27'd0, fifo_elems}, 32'd16);
    #1;
    chk("t5_write_full", {31'd0, fifo_write}, 32'd1);
    @(negedge clk);
    rx_push = 1'b0;
    chk("t5_oe_set", {31'd0, m_oe}, 32'd1);
    lsr_rd = 1'b1;
    #1;
    chk("t5_clr_flag", {31'd0, fifo_clear_flag}, 32'd1);
    @(negedge clk);
    lsr_rd = 1'b0;
    #1;
    chk("t5_clr_flag_off", {31'd0, fifo_clear_flag}, 32'd0);
    chk("t5_oe_clr", {31'd0, m_oe}, 32'd0);
    rx_push = 1'b1;
    @(negedge clk);
    rx_push = 1'b0;
    chk("t5_oe_again", {31'd0, m_oe}, 32'd1);
    expect_drain(16);
    fcr_write(8'h03);
    run_drain(5, 40);
    chk("t5_oe_kept", {31'd0, m_oe}, 32'd1);
    chk("t5_elems0", {27'd0, fifo_elems}, 32'd0);
    chk("t5_busy_done", {31'd0, rx_busy}, 32'd0);

    // TX flush without RX effect.
    fcr_write(8'h05);
    chk("t6_flush", {31'd0, tx_flush}, 32'd1);
    chk("t6_no_drain", {31'd0, rx_busy}, 32'd0);
    @(negedge clk);
    chk("t6_flush_end", {31'd0, tx_flush}, 32'd0);

    // Reset in the middle of a drain.
    rx_push = 1'b1;
    repeat (5) @(negedge clk);
    rx_push = 1'b0;
    fcr_write(8'h03);
    #1;
    chk("t6_drain_rd1", {31'd0, fifo_read}, 32'd1);
    @(negedge clk);
    chk("t6_drain_rd2", {31'd0, fifo_read}, 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_rd", {31'd0, fifo_read}, 32'd0);
    @(negedge clk);
    chk("t6_rst_regmode", {31'd0, fifo_regmode}, 32'd1);
    chk("t6_rst_busy", {31'd0, rx_busy}, 32'd0);
    chk("t6_rst_en", {31'd0, fifo_en}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_no_more_reads", {27'd0, fifo_elems}, 32'd3);
    chk("t6_idle_rd", {31'd0, fifo_read}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected end of sequence");
    $fatal(1, "watchdog");
  end

endmodule
